// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary-to-BCD requester and the converter.
// The master drives start/bin; the slave answers with busy/done/bcd/ovf.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (output start, output bin, input busy, input done, input bcd, input ovf);
    modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock,
// BIN_W clocks per conversion, result and overflow flag held until the next done.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    logic [BCD_W-1:0]    corr_s;
    logic [WORK_W-1:0]   shifted_s;
    logic                shift_out_s;
    logic                last_s;

    // Add 3 to every digit that is 5 or more, each digit on its own (no inter-digit carry).
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Datapath of one double-dabble step on the current working register.
    always_comb begin
        corr_s      = add3_digits(work_q[WORK_W-1 -: BCD_W]);
        shifted_s   = {corr_s[BCD_W-2:0], work_q[BIN_W-1:0], 1'b0};
        shift_out_s = corr_s[BCD_W-1];
        last_s      = (cnt_q == CNT_W'(BIN_W - 1));
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d    = {{BCD_W{1'b0}}, bus.bin};
                    cnt_d     = {CNT_W{1'b0}};
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                work_d    = shifted_s;
                cnt_d     = cnt_q + CNT_W'(1);
                ovf_acc_d = ovf_acc_q | shift_out_s;
                // Final shift: publish the result straight from the shifter output.
                if (last_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    bcd_d   = shifted_s[WORK_W-1 -: BCD_W];
                    ovf_d   = ovf_acc_q | shift_out_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= {WORK_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= {BCD_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations (8/3, 8/2, 1/1) sharing one clock and
// reset, with a queue of expected results per instance popped when done appears.
module tb_bin2bcd_seq;
    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   done_cnt_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus_a ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) bus_b ();
    bin2bcd_seq_if #(.BIN_W(1), .DIGITS(1)) bus_c ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    always @(posedge clk) begin
        if (bus_a.done === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    // Reference model: decimal digits of v truncated to 'digits', overflow when v >= 10^digits.
    function automatic exp_t model(input int v, input int digits);
        exp_t e;
        int   x;
        int   lim;
        e.bcd = 12'h000;
        x     = v;
        lim   = 1;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(x % 10);
            x   = x / 10;
            lim = lim * 10;
        end
        e.ovf = (v >= lim);
        return e;
    endfunction

    // Wait (bounded) for done on instance A; call at a negedge with start already driven.
    task automatic wait_done_a(output int lat, output int bcnt, output bit both);
        lat = -1; bcnt = 0; both = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (bus_a.busy === 1'b1) bcnt++;
            if (bus_a.busy === 1'b1 && bus_a.done === 1'b1) both = 1'b1;
            if (bus_a.done === 1'b1) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic test_reset;
        chk_cnt++;
        if ({bus_a.busy, bus_a.done, bus_a.ovf} !== 3'b000) $display("FAIL reset_ctl_a got %b want 000", {bus_a.busy, bus_a.done, bus_a.ovf});
        else pass_cnt++;
        chk_cnt++;
        if (bus_a.bcd !== 12'h000) $display("FAIL reset_bcd_a got %h want 000", bus_a.bcd);
        else pass_cnt++;
        chk_cnt++;
        if ({bus_b.busy, bus_b.done, bus_b.ovf, bus_b.bcd} !== 11'h000) $display("FAIL reset_b got %h want 000", {bus_b.busy, bus_b.done, bus_b.ovf, bus_b.bcd});
        else pass_cnt++;
        chk_cnt++;
        if ({bus_c.busy, bus_c.done, bus_c.ovf, bus_c.bcd} !== 7'h00) $display("FAIL reset_c got %h want 00", {bus_c.busy, bus_c.done, bus_c.ovf, bus_c.bcd});
        else pass_cnt++;
    endtask

    task automatic test_single;
        int lat, bcnt; bit both; exp_t e;
        bus_a.start = 1'b1; bus_a.bin = 8'd255;
        q_a.push_back(model(255, 3));
        wait_done_a(lat, bcnt, both);
        chk_cnt++;
        if (lat !== 8) $display("FAIL single_latency got %0d want 8", lat); else pass_cnt++;
        chk_cnt++;
        if (bcnt !== 8) $display("FAIL single_busy_cycles got %0d want 8", bcnt); else pass_cnt++;
        chk_cnt++;
        if (both) $display("FAIL single_busy_done_overlap got 1 want 0"); else pass_cnt++;
        e = q_a.pop_front();
        chk_cnt++;
        if ({bus_a.bcd, bus_a.ovf} !== {e.bcd, e.ovf}) $display("FAIL single_result got %h/%b want %h/%b", bus_a.bcd, bus_a.ovf, e.bcd, e.ovf);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus_a.done !== 1'b0) $display("FAIL single_done_pulse got %b want 0", bus_a.done); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat, bcnt; bit both; exp_t e;
        bus_a.start = 1'b1; bus_a.bin = 8'd0;
        q_a.push_back(model(0, 3));
        for (int v = 0; v < 256; v++) begin
            wait_done_a(lat, bcnt, both);
            chk_cnt++;
            if (lat !== 8 || both) $display("FAIL b2b_latency v=%0d got %0d want 8", v, lat); else pass_cnt++;
            chk_cnt++;
            if (q_a.size() == 0) begin
                $display("FAIL b2b_queue_empty v=%0d got done want none", v);
            end else begin
                e = q_a.pop_front();
                if ({bus_a.bcd, bus_a.ovf} !== {e.bcd, e.ovf}) $display("FAIL b2b_result v=%0d got %h/%b want %h/%b", v, bus_a.bcd, bus_a.ovf, e.bcd, e.ovf);
                else pass_cnt++;
            end
            if (v < 255) begin
                bus_a.start = 1'b1; bus_a.bin = 8'(v + 1);
                q_a.push_back(model(v + 1, 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int ndone = 0, first = -1; int lat, bcnt; bit both; exp_t e;
        bus_a.start = 1'b1; bus_a.bin = 8'd42;
        q_a.push_back(model(42, 3));
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            bus_a.start = (j == 2);
            if (j == 2) bus_a.bin = 8'd99;
            if (bus_a.done === 1'b1) begin
                ndone++;
                if (first < 0) first = j;
            end
        end
        bus_a.start = 1'b0;
        chk_cnt++;
        if (ndone !== 1 || first !== 8) $display("FAIL ignore_done got %0d dones at %0d want 1 at 8", ndone, first); else pass_cnt++;
        e = q_a.pop_front();
        chk_cnt++;
        if (bus_a.bcd !== e.bcd) $display("FAIL ignore_hold got %h want %h", bus_a.bcd, e.bcd); else pass_cnt++;
        bus_a.start = 1'b1; bus_a.bin = 8'd123;
        q_a.push_back(model(123, 3));
        for (int j = 0; j < 5; j++) @(negedge clk);
        bus_a.start = 1'b0;
        chk_cnt++;
        if (bus_a.bcd !== 12'h042) $display("FAIL ignore_bcd_mid got %h want 042", bus_a.bcd); else pass_cnt++;
        wait_done_a(lat, bcnt, both);
        e = q_a.pop_front();
        chk_cnt++;
        if (lat !== 3 || bus_a.bcd !== e.bcd) $display("FAIL ignore_next got %h at %0d want %h at 3", bus_a.bcd, lat, e.bcd); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bcnt; bit both; int base; exp_t e;
        bus_a.start = 1'b1; bus_a.bin = 8'd200;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus_a.busy, bus_a.done, bus_a.bcd} !== 14'h0000) $display("FAIL rstmid_clear got %h want 0000", {bus_a.busy, bus_a.done, bus_a.bcd}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt_a;
        for (int j = 0; j < 12; j++) @(negedge clk);
        chk_cnt++;
        if (done_cnt_a !== base || bus_a.busy !== 1'b0) $display("FAIL rstmid_no_done got %0d dones busy %b want 0 dones busy 0", done_cnt_a - base, bus_a.busy); else pass_cnt++;
        bus_a.start = 1'b1; bus_a.bin = 8'd7;
        q_a.push_back(model(7, 3));
        wait_done_a(lat, bcnt, both);
        e = q_a.pop_front();
        chk_cnt++;
        if (lat !== 8 || bus_a.bcd !== e.bcd) $display("FAIL rstmid_restart got %h at %0d want %h at 8", bus_a.bcd, lat, e.bcd); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int vals[2] = '{200, 99};
        int lat; exp_t e;
        foreach (vals[i]) begin
            bus_b.start = 1'b1; bus_b.bin = 8'(vals[i]);
            q_b.push_back(model(vals[i], 2));
            lat = -1;
            for (int j = 0; j < 40; j++) begin
                @(negedge clk);
                bus_b.start = 1'b0;
                if (bus_b.done === 1'b1) begin lat = j; break; end
            end
            e = q_b.pop_front();
            chk_cnt++;
            if (lat !== 8 || {4'h0, bus_b.bcd} !== e.bcd || bus_b.ovf !== e.ovf)
                $display("FAIL ovf_%0d got %h/%b at %0d want %h/%b at 8", vals[i], bus_b.bcd, bus_b.ovf, lat, e.bcd[7:0], e.ovf);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_min_width;
        int lat; exp_t e;
        for (int v = 1; v >= 0; v--) begin
            bus_c.start = 1'b1; bus_c.bin = 1'(v);
            q_c.push_back(model(v, 1));
            lat = -1;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                bus_c.start = 1'b0;
                if (bus_c.done === 1'b1) begin lat = j; break; end
            end
            e = q_c.pop_front();
            chk_cnt++;
            if (lat !== 1 || {8'h00, bus_c.bcd} !== e.bcd || bus_c.ovf !== e.ovf)
                $display("FAIL minw_%0d got %h/%b at %0d want %h/%b at 1", v, bus_c.bcd, bus_c.ovf, lat, e.bcd[3:0], e.ovf);
            else pass_cnt++;
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.bin = 8'd0;
        bus_b.start = 1'b0; bus_b.bin = 8'd0;
        bus_c.start = 1'b0; bus_c.bin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_overflow();
        test_min_width();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
